// File: rtl/enable_seq_pkg.sv
// Shared types and widths for the enable sequencer.
// One table step is a channel mask plus a hold time in cycles.
package enable_seq_pkg;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int LEN_W  = IDX_W + 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  typedef struct packed {
    logic [NUM_CH-1:0] mask;
    logic [CNT_W-1:0]  hold;
  } step_t;

  // A hold of zero still shows its step for one cycle.
  function automatic logic [CNT_W-1:0] hold_reload(
    input logic [CNT_W-1:0] h
  );
    logic [CNT_W-1:0] r;
    r = '0;
    if (h != '0) r = h - 1'b1;
    return r;
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(
    input logic [LEN_W-1:0] l
  );
    logic [LEN_W-1:0] r;
    r = l;
    if (l > LEN_W'(DEPTH)) r = LEN_W'(DEPTH);
    return r;
  endfunction

endpackage

// File: rtl/enable_seq_table.sv
// Step table: one write port, one async read port,
// synchronous clear of every entry.
module enable_seq_table
  import enable_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_addr,
  input  step_t            wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output step_t            rd_data
);

  step_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/enable_seq.sv
// Plays (mask, hold) steps from the table onto registered
// enable lines, one-shot or looping until abort.
module enable_seq
  import enable_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [NUM_CH-1:0] cfg_mask,
  input  logic [CNT_W-1:0]  cfg_hold,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              repeat_en,
  input  logic              start,
  input  logic              abort,
  output logic [NUM_CH-1:0] enable,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  step_idx
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              rep_q, rep_d;

  logic              tbl_we;
  logic [IDX_W-1:0]  rd_addr;
  step_t             rd_data;
  step_t             wr_step;
  step_t             nxt_step;
  logic              is_last;
  logic [LEN_W-1:0]  len_eff;

  // Table is frozen while playing.
  assign tbl_we  = cfg_we && (state_q == IDLE);
  assign wr_step = '{mask: cfg_mask, hold: cfg_hold};
  assign len_eff = clamp_len(cfg_len);
  assign is_last = ({1'b0, idx_q} == (len_q - 1'b1));

  assign rd_addr = (state_q == RUN && !is_last)
                 ? idx_q + 1'b1 : '0;

  // A write to step 0 in the start cycle must be what plays.
  assign nxt_step = (tbl_we && cfg_addr == '0)
                  ? wr_step : rd_data;

  enable_seq_table u_table (
    .clk     (clk),
    .rst     (rst),
    .we      (tbl_we),
    .wr_addr (cfg_addr),
    .wr_data (wr_step),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    len_d   = len_q;
    rep_d   = rep_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (len_eff == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
            idx_d   = '0;
            en_d    = nxt_step.mask;
            cnt_d   = hold_reload(nxt_step.hold);
            len_d   = len_eff;
            rep_d   = repeat_en;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          en_d    = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (is_last && !rep_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          en_d    = '0;
          idx_d   = '0;
        end else begin
          idx_d = is_last ? '0 : idx_q + 1'b1;
          en_d  = nxt_step.mask;
          cnt_d = hold_reload(nxt_step.hold);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        en_d    = '0;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      en_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      len_q   <= '0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      len_q   <= len_d;
      rep_q   <= rep_d;
    end
  end

  assign enable   = en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = idx_q;

endmodule

// File: tb/tb_enable_seq.sv
// Directed bench for the enable sequencer.
// Each task drives one scenario and checks inline.
module tb_enable_seq;
  import enable_seq_pkg::*;

  logic              clk;
  logic              rst;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_addr;
  logic [NUM_CH-1:0] cfg_mask;
  logic [CNT_W-1:0]  cfg_hold;
  logic [LEN_W-1:0]  cfg_len;
  logic              repeat_en;
  logic              start;
  logic              abort;
  logic [NUM_CH-1:0] enable;
  logic              busy;
  logic              done;
  logic [IDX_W-1:0]  step_idx;

  int checks;
  int failures;

  logic [3:0] pat_en  [6];
  logic [2:0] pat_idx [6];

  enable_seq dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_mask  (cfg_mask),
    .cfg_hold  (cfg_hold),
    .cfg_len   (cfg_len),
    .repeat_en (repeat_en),
    .start     (start),
    .abort     (abort),
    .enable    (enable),
    .busy      (busy),
    .done      (done),
    .step_idx  (step_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_step(input int a, input int m, input int h);
    cfg_we   = 1'b1;
    cfg_addr = IDX_W'(a);
    cfg_mask = NUM_CH'(m);
    cfg_hold = CNT_W'(h);
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic do_start(input int len, input logic rep);
    cfg_len   = LEN_W'(len);
    repeat_en = rep;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic load_basic();
    wr_step(0, 'h1, 3);
    wr_step(1, 'hF, 2);
    wr_step(2, 'h0, 1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if (enable !== 4'h0 || busy !== 1'b0 || done !== 1'b0
        || step_idx !== 3'd0) begin
      failures++;
      $display("FAIL reset en=%h busy=%b done=%b idx=%0d want 0",
               enable, busy, done, step_idx);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_oneshot();
    load_basic();
    do_start(3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (enable !== pat_en[i] || busy !== 1'b1
          || step_idx !== pat_idx[i] || done !== 1'b0) begin
        failures++;
        $display("FAIL oneshot[%0d] en=%h idx=%0d busy=%b want en=%h idx=%0d busy=1",
                 i, enable, step_idx, busy, pat_en[i], pat_idx[i]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || enable !== 4'h0) begin
      failures++;
      $display("FAIL oneshot_end done=%b busy=%b en=%h want 1,0,0",
               done, busy, enable);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL oneshot_pulse done=%b want 0", done);
    end
  endtask

  task automatic test_repeat();
    int bad;
    bad = 0;
    do_start(3, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (enable !== pat_en[i % 6] || busy !== 1'b1
          || done !== 1'b0) begin
        bad++;
        $display("FAIL repeat[%0d] en=%h busy=%b done=%b want en=%h",
                 i, enable, busy, done, pat_en[i % 6]);
      end
      tick();
    end
    checks++;
    if (bad != 0) failures++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (enable !== 4'h0 || busy !== 1'b0 || done !== 1'b0
        || step_idx !== 3'd0) begin
      failures++;
      $display("FAIL abort en=%h busy=%b done=%b idx=%0d want 0",
               enable, busy, done, step_idx);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL abort_nodone done=%b want 0", done);
    end
  endtask

  task automatic test_hold_zero();
    wr_step(0, 'h3, 0);
    wr_step(1, 'hC, 1);
    do_start(2, 1'b0);
    checks++;
    if (enable !== 4'h3 || busy !== 1'b1) begin
      failures++;
      $display("FAIL hold0_a en=%h busy=%b want 3,1", enable, busy);
    end
    tick();
    checks++;
    if (enable !== 4'hC || step_idx !== 3'd1) begin
      failures++;
      $display("FAIL hold0_b en=%h idx=%0d want C,1", enable, step_idx);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL hold0_end done=%b busy=%b want 1,0", done, busy);
    end
    tick();
  endtask

  task automatic test_hold_max();
    int n;
    int held;
    n = 0;
    held = 0;
    wr_step(0, 'h5, 'hFFFF);
    do_start(1, 1'b0);
    while (busy === 1'b1 && n < 70000) begin
      if (enable === 4'h5) held++;
      n++;
      tick();
    end
    checks++;
    if (held != 65535 || n != 65535) begin
      failures++;
      $display("FAIL hold_max held=%0d busy_cycles=%0d want 65535",
               held, n);
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL hold_max_done done=%b want 1", done);
    end
    tick();
  endtask

  task automatic test_len_zero();
    int pulses;
    pulses = 0;
    do_start(0, 1'b0);
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL len0 busy=%b done=%b want 0,1", busy, done);
    end
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL len0_pulse count=%0d want 1", pulses);
    end
  endtask

  task automatic test_start_abort();
    abort = 1'b1;
    do_start(3, 1'b0);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || enable !== 4'h0) begin
      failures++;
      $display("FAIL start_abort busy=%b done=%b en=%h want 0",
               busy, done, enable);
    end
    tick();
  endtask

  task automatic test_busy_ignore();
    int bad;
    bad = 0;
    load_basic();
    do_start(3, 1'b1);
    for (int i = 0; i < 12; i++) begin
      if (enable !== pat_en[i % 6]
          || step_idx !== pat_idx[i % 6]) begin
        bad++;
        $display("FAIL busy_ign[%0d] en=%h idx=%0d want en=%h idx=%0d",
                 i, enable, step_idx, pat_en[i % 6], pat_idx[i % 6]);
      end
      if (i == 2) begin
        cfg_we   = 1'b1;
        cfg_addr = '0;
        cfg_mask = 4'h8;
        cfg_hold = 16'd1;
      end
      if (i == 4) start = 1'b1;
      tick();
      cfg_we = 1'b0;
      start  = 1'b0;
    end
    checks++;
    if (bad != 0) failures++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_we_start();
    cfg_we   = 1'b1;
    cfg_addr = '0;
    cfg_mask = 4'hA;
    cfg_hold = 16'd1;
    do_start(1, 1'b0);
    cfg_we = 1'b0;
    checks++;
    if (enable !== 4'hA || busy !== 1'b1) begin
      failures++;
      $display("FAIL we_start en=%h busy=%b want A,1", enable, busy);
    end
    tick();
    checks++;
    if (done !== 1'b1 || enable !== 4'h0) begin
      failures++;
      $display("FAIL we_start_end done=%b en=%h want 1,0", done, enable);
    end
    tick();
  endtask

  task automatic test_len_clamp();
    int bad;
    bad = 0;
    for (int i = 0; i < 8; i++) wr_step(i, i + 1, 1);
    do_start(15, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (enable !== 4'(i + 1) || step_idx !== 3'(i)
          || busy !== 1'b1) begin
        bad++;
        $display("FAIL clamp[%0d] en=%h idx=%0d want en=%h idx=%0d",
                 i, enable, step_idx, 4'(i + 1), i);
      end
      tick();
    end
    checks++;
    if (bad != 0) failures++;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clamp_end done=%b busy=%b want 1,0", done, busy);
    end
    tick();
  endtask

  task automatic test_rst_mid();
    int bad;
    bad = 0;
    load_basic();
    do_start(3, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (enable !== 4'h0 || busy !== 1'b0 || step_idx !== 3'd0
        || done !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid en=%h busy=%b idx=%0d done=%b want 0",
               enable, busy, step_idx, done);
    end
    do_start(3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (enable !== 4'h0 || busy !== 1'b1
          || step_idx !== 3'(i)) begin
        bad++;
        $display("FAIL rst_tbl[%0d] en=%h busy=%b idx=%0d want 0,1,%0d",
                 i, enable, busy, step_idx, i);
      end
      tick();
    end
    checks++;
    if (bad != 0) failures++;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_tbl_end done=%b busy=%b want 1,0", done, busy);
    end
    tick();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    pat_en    = '{4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'h0};
    pat_idx   = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2};
    rst       = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_mask  = '0;
    cfg_hold  = '0;
    cfg_len   = '0;
    repeat_en = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    tick();
    test_reset();
    test_oneshot();
    test_repeat();
    test_hold_zero();
    test_hold_max();
    test_len_zero();
    test_start_abort();
    test_busy_ignore();
    test_we_start();
    test_len_clamp();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
